// File: rtl/bcd_pkg.sv
// ============================================================================
// Module : bcd_pkg
// Purpose: Shared types and constants for the digit-serial BCD add/subtract
//          datapath: the packed-BCD digit type, the nine's-complement and
//          decimal-correction constants, and the controller state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;
  localparam bcd_digit_t BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adder.sv
// ============================================================================
// Module : bcd_digit_adder
// Purpose: Combinational single-digit decimal adder with +6 correction.
// Ports  : x, y  - 4-bit addend digits
//          cin   - decimal carry in
//          s     - corrected sum digit
//          cout  - decimal carry out (raw sum exceeded 9)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] raw_sum;

  always_comb begin
    raw_sum = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    if (raw_sum > 5'd9) begin
      // Adding 6 modulo 16 skips the six unused codes A..F.
      s    = raw_sum[3:0] + BCD_CORR;
      cout = 1'b1;
    end else begin
      s    = raw_sum[3:0];
      cout = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_addsub_serial.sv
// ============================================================================
// Module : bcd_addsub_serial
// Purpose: Digit-serial packed-BCD adder/subtractor with start/done handshake.
//          One shared digit adder processes one digit per clock. Subtraction
//          adds the nine's complement of B plus one; a negative outcome is
//          turned into sign-magnitude by a second serial ten's-complement pass.
// Ports  : clk, reset (sync, active high)
//          start, op (0 add / 1 sub), a, b      - request side
//          ready, done, result, sign, carry, err - response side
// Config : BCD_INPUT_CHECK_EN - when defined, non-BCD operand digits raise err
//          and the operation completes immediately with a zero result.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                op,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                ready,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                sign,
  output logic                carry,
  output logic                err
);

  localparam int IW = $clog2(DIGITS);

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] a_q, a_d;
  logic [4*DIGITS-1:0] b_q, b_d;
  logic [4*DIGITS-1:0] result_q, result_d;
  logic                op_q, op_d;
  logic                c_q, c_d;
  logic                sign_q, sign_d;
  logic                carry_q, carry_d;
  logic                err_q, err_d;
  logic [IW-1:0]       idx_q, idx_d;

  logic [IW+1:0]       bit_pos;
  logic                last_digit;
  logic                bad_in;
  bcd_digit_t          add_x, add_y, add_s, b_dig;
  logic                add_cout;

  assign bit_pos    = {idx_q, 2'b00};
  assign last_digit = (idx_q == IW'(DIGITS - 1));

`ifdef BCD_INPUT_CHECK_EN
  always_comb begin
    bad_in = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (a[4*k +: 4] > BCD_NINE || b[4*k +: 4] > BCD_NINE) begin
        bad_in = 1'b1;
      end
    end
  end
`else
  assign bad_in = 1'b0;
`endif

  // Operand multiplexer: RUN adds A to B (or to 9-B when subtracting);
  // FIX re-adds 9-d of the stored sum with a zero addend.
  always_comb begin
    b_dig = b_q[bit_pos +: 4];
    if (state_q == FIX) begin
      add_x = BCD_NINE - result_q[bit_pos +: 4];
      add_y = 4'd0;
    end else begin
      add_x = a_q[bit_pos +: 4];
      add_y = op_q ? (BCD_NINE - b_dig) : b_dig;
    end
  end

  bcd_digit_adder u_digit_adder (
    .x    (add_x),
    .y    (add_y),
    .cin  (c_q),
    .s    (add_s),
    .cout (add_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    c_d      = c_q;
    idx_d    = idx_q;
    result_d = result_q;
    sign_d   = sign_q;
    carry_d  = carry_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          idx_d    = '0;
          c_d      = op;  // the +1 of the ten's complement of B
          result_d = '0;
          sign_d   = 1'b0;
          carry_d  = 1'b0;
          err_d    = bad_in;
          state_d  = bad_in ? DONE : RUN;
        end
      end
      RUN: begin
        result_d[bit_pos +: 4] = add_s;
        c_d   = add_cout;
        idx_d = idx_q + 1'b1;
        if (last_digit) begin
          idx_d = '0;
          if (!op_q) begin
            carry_d = add_cout;
            state_d = DONE;
          end else if (add_cout) begin
            state_d = DONE;
          end else begin
            // No end-around carry: the stored value is the ten's complement
            // of the magnitude, so complement it back.
            sign_d  = 1'b1;
            c_d     = 1'b1;
            state_d = FIX;
          end
        end
      end
      FIX: begin
        result_d[bit_pos +: 4] = add_s;
        c_d   = add_cout;
        idx_d = idx_q + 1'b1;
        if (last_digit) begin
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      c_q      <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      sign_q   <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      c_q      <= c_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign sign   = sign_q;
  assign carry  = carry_q;
  assign err    = err_q;

endmodule

`default_nettype wire
